// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the control, decode and status signals of the
// program-counter sequencer.
//   master : the surrounding system (front panel, decoder, memory). It drives
//            run, step, stall and the decoded halt/branch information.
//   slave  : the sequencer itself. It drives pc, fetch_en, exec_en, halted,
//            pc_wrap and instr_count.
interface pc_sequencer_if #(
   parameter int PC_WIDTH  = 6,
   parameter int CNT_WIDTH = 16
);
   logic                 run;
   logic                 step;
   logic                 stall;
   logic                 halt_instr;
   logic                 branch_valid;
   logic                 branch_taken;
   logic [PC_WIDTH-1:0]  branch_offset;
   logic [PC_WIDTH-1:0]  pc;
   logic                 fetch_en;
   logic                 exec_en;
   logic                 halted;
   logic                 pc_wrap;
   logic [CNT_WIDTH-1:0] instr_count;

   modport master (
      output run, step, stall, halt_instr, branch_valid, branch_taken, branch_offset,
      input  pc, fetch_en, exec_en, halted, pc_wrap, instr_count
   );

   modport slave (
      input  run, step, stall, halt_instr, branch_valid, branch_taken, branch_offset,
      output pc, fetch_en, exec_en, halted, pc_wrap, instr_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the CPU program counter and steps each instruction
// through a two-phase FETCH/EXEC cycle. The next PC is PC+1, or
// PC+1+signed offset for a taken branch, modulo 2^PC_WIDTH.
// Ports:
//   clk      : system clock; all state changes on its rising edge
//   reset_n  : asynchronous active-low reset, released synchronously
//   bus      : pc_sequencer_if slave modport
//              (run/step/stall/decode inputs; pc/enables/status outputs)
module pc_sequencer #(
   parameter int                  PC_WIDTH  = 6,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
   parameter int                  CNT_WIDTH = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   pc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_FETCH  = 2'b01,
      ST_EXEC   = 2'b10,
      ST_HALTED = 2'b11
   } state_t;

   localparam logic [PC_WIDTH+1:0]  PC_ONE  = {{(PC_WIDTH+1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t               state_r;
   state_t               state_next_s;
   logic [PC_WIDTH-1:0]  pc_r;
   logic [PC_WIDTH-1:0]  pc_next_s;
   logic [CNT_WIDTH-1:0] count_r;
   logic                 wrap_r;
   logic                 step_pending_r;
   logic                 step_pending_next_s;
   logic                 retire_s;
   logic                 taken_s;
   logic                 wrap_hit_s;
   logic [PC_WIDTH+1:0]  offset_ext_s;
   logic [PC_WIDTH+1:0]  sum_s;

   // Next-PC adder, two bits wider than the PC: any nonzero value in those
   // two top bits means the exact sum left [0, 2^PC_WIDTH-1].
   always_comb begin
      taken_s      = bus.branch_valid & bus.branch_taken;
      offset_ext_s = {{2{bus.branch_offset[PC_WIDTH-1]}}, bus.branch_offset};
      if (taken_s) begin
         sum_s = {2'b00, pc_r} + PC_ONE + offset_ext_s;
      end else begin
         sum_s = {2'b00, pc_r} + PC_ONE;
      end
      pc_next_s  = sum_s[PC_WIDTH-1:0];
      wrap_hit_s = sum_s[PC_WIDTH+1] | sum_s[PC_WIDTH];
   end

   // Next-state logic; retire_s marks the EXEC cycle that completes an instruction.
   always_comb begin
      state_next_s        = state_r;
      step_pending_next_s = step_pending_r;
      retire_s            = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.run | (bus.step & ~step_pending_r)) begin
               state_next_s        = ST_FETCH;
               step_pending_next_s = step_pending_r | bus.step;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (bus.stall) begin
               state_next_s = ST_FETCH;
            end else begin
               state_next_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (bus.stall) begin
               state_next_s = ST_EXEC;
            end else begin
               retire_s = 1'b1;
               if (bus.halt_instr) begin
                  state_next_s = ST_HALTED;
               end else if (bus.run) begin
                  state_next_s = ST_FETCH;
               end else begin
                  state_next_s        = ST_IDLE;
                  step_pending_next_s = 1'b0;
               end
            end
         end
         ST_HALTED: begin
            state_next_s = ST_HALTED;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state, PC, sticky wrap flag and saturating retire counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r        <= ST_IDLE;
         step_pending_r <= 1'b0;
         pc_r           <= RESET_PC;
         wrap_r         <= 1'b0;
         count_r        <= {CNT_WIDTH{1'b0}};
      end else begin
         state_r        <= state_next_s;
         step_pending_r <= step_pending_next_s;
         if (retire_s && !bus.halt_instr) begin
            pc_r <= pc_next_s;
            if (wrap_hit_s) begin
               wrap_r <= 1'b1;
            end
         end
         if (retire_s && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
         end
      end
   end

   // Moore enables, forced low while the sequencer is stalled.
   always_comb begin
      bus.fetch_en    = (state_r == ST_FETCH) & ~bus.stall;
      bus.exec_en     = (state_r == ST_EXEC) & ~bus.stall;
      bus.halted      = (state_r == ST_HALTED);
      bus.pc          = pc_r;
      bus.pc_wrap     = wrap_r;
      bus.instr_count = count_r;
   end

endmodule
